// File: rtl/present_round_ctrl.sv
// PRESENT-80 round sequencer: one cipher round per clock with the key schedule in lockstep,
// then a final key add and a one-cycle Done pulse.
module present_round_ctrl #(
    parameter int unsigned SIZE     = 64,
    parameter int unsigned KEY_BITS = 80,
    parameter int unsigned ROUNDS   = 31
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [SIZE-1:0]     Plaintext,
    input  logic [KEY_BITS-1:0] Key,
    output logic                Ready,
    output logic                Busy,
    output logic                Done,
    output logic [SIZE-1:0]     Ciphertext,
    output logic [4:0]          Round
);

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

    localparam logic [4:0] RoundsLast = 5'(ROUNDS);

    state_e              state_q;
    logic [SIZE-1:0]     block_q;
    logic [KEY_BITS-1:0] key_q;
    logic [SIZE-1:0]     ct_q;
    logic [4:0]          round_q;
    logic                done_q;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to (16*i) mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        int unsigned j;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            j = (16 * i) % 63;
            y[j[5:0]] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rnd);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ rnd;
        return r;
    endfunction

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            block_q <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        block_q <= Plaintext;
                        key_q   <= Key;
                        round_q <= 5'd1;
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    block_q <= p_layer(s_layer(block_q ^ key_q[79:16]));
                    key_q   <= key_update(key_q, round_q);
                    if (round_q == RoundsLast) begin
                        round_q <= '0;
                        state_q <= StFinal;
                    end else begin
                        round_q <= round_q + 5'd1;
                    end
                end
                StFinal: begin
                    ct_q    <= block_q ^ key_q[79:16];
                    done_q  <= 1'b1;
                    round_q <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Ready      = (state_q == StIdle);
    assign Busy       = (state_q == StRound) || (state_q == StFinal);
    assign Done       = done_q;
    assign Ciphertext = ct_q;
    assign Round      = round_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: known PRESENT-80 vectors, random blocks checked
// against a plain-arithmetic cipher model, per-cycle handshake/round trace, Start-while-busy, reset abort.
module tb_present_round_ctrl;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [63:0] Plaintext;
    logic [79:0] Key;
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic [63:0] Ciphertext;
    logic [4:0]  Round;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_round_ctrl #(.SIZE(64), .KEY_BITS(80), .ROUNDS(31)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Plaintext  (Plaintext),
        .Key        (Key),
        .Ready      (Ready),
        .Busy       (Busy),
        .Done       (Done),
        .Ciphertext (Ciphertext),
        .Round      (Round)
    );

    always #5 Clock = ~Clock;

    // Whole-cipher reference: 31 rounds of key add / S-box / bit permutation, then final key add.
    function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, t, p;
        logic [79:0] k;
        logic [4:0]  rc;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
            p = '0;
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = t[i];
            s = p;
            k = (k << 61) | (k >> 19);
            k[79:76] = SB[k[79:76]];
            rc = 5'(r);
            k[19:15] = k[19:15] ^ rc;
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT idle. poke_at > 0 re-pulses Start with other data.
    task automatic encrypt(input logic [63:0] pt, input logic [79:0] key, input int poke_at,
                           input logic [63:0] exp_ct, input string tag);
        Start     = 1'b1;
        Plaintext = pt;
        Key       = key;
        check({tag, " ready_at_accept"}, 80'(Ready), 80'(1));
        @(posedge Clock);
        @(negedge Clock);
        Start     = 1'b0;
        Plaintext = {$urandom(), $urandom()};
        Key       = {$urandom(), $urandom(), 16'($urandom())};
        for (int c = 1; c <= 33; c++) begin
            check({tag, " round"}, 80'(Round), 80'((c <= 31) ? c : 0));
            check({tag, " busy"},  80'(Busy),  80'(c <= 32));
            check({tag, " ready"}, 80'(Ready), 80'(c == 33));
            check({tag, " done"},  80'(Done),  80'(c == 33));
            if (c == 33) check({tag, " ciphertext"}, 80'(Ciphertext), 80'(exp_ct));
            if (c == poke_at) begin
                Start     = 1'b1;
                Plaintext = ~pt;
                Key       = ~key;
            end
            if (c == poke_at + 1) Start = 1'b0;
            if (c < 33) @(negedge Clock);
        end
        @(negedge Clock);
        check({tag, " done_width"}, 80'(Done), 80'(0));
        check({tag, " ct_hold"}, 80'(Ciphertext), 80'(exp_ct));
    endtask

    initial begin
        logic [63:0] pt;
        logic [79:0] key;
        int          done_at[$];
        int          n_done;

        Reset_n   = 1'b0;
        Start     = 1'b0;
        Plaintext = '0;
        Key       = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst ready", 80'(Ready), 80'(1));
        check("rst busy",  80'(Busy),  80'(0));
        check("rst done",  80'(Done),  80'(0));
        check("rst ct",    80'(Ciphertext), 80'(0));
        check("rst round", 80'(Round), 80'(0));
        Reset_n = 1'b1;
        @(negedge Clock);

        encrypt(64'h0, 80'h0, 0, 64'h5579C1387B228445, "vec1");
        encrypt(64'h0, {80{1'b1}}, 0, 64'hE72C46C0F5945049, "vec2");
        encrypt({64{1'b1}}, 80'h0, 0, 64'hA112FFC72F68417B, "vec3a");

        // Start held high: back-to-back blocks, Done pulses one block period apart.
        Start     = 1'b1;
        Plaintext = {64{1'b1}};
        Key       = {80{1'b1}};
        for (int c = 1; c <= 70; c++) begin
            @(negedge Clock);
            if (Done) begin
                done_at.push_back(c);
                check("held ct", 80'(Ciphertext), 80'(64'h3333DCD3213210D2));
            end
        end
        Start = 1'b0;
        check("held done count", 80'(done_at.size()), 80'(2));
        if (done_at.size() == 2) begin
            check("held first done", 80'(done_at[0]), 80'(33));
            check("held spacing", 80'(done_at[1] - done_at[0]), 80'(33));
        end
        repeat (40) @(negedge Clock);
        check("held drained", 80'(Ready), 80'(1));

        // Start re-pulsed mid-encryption with other data must be ignored.
        pt  = {$urandom(), $urandom()};
        key = {$urandom(), $urandom(), 16'($urandom())};
        encrypt(pt, key, 10, ref_encrypt(pt, key), "poke");

        // Reset abort at round 20.
        Start     = 1'b1;
        Plaintext = {$urandom(), $urandom()};
        Key       = {$urandom(), $urandom(), 16'($urandom())};
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        repeat (19) @(negedge Clock);
        check("abort round", 80'(Round), 80'(20));
        Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        check("abort ready", 80'(Ready), 80'(1));
        check("abort busy",  80'(Busy),  80'(0));
        check("abort done",  80'(Done),  80'(0));
        check("abort ct",    80'(Ciphertext), 80'(0));
        check("abort round0", 80'(Round), 80'(0));
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            if (Done) n_done++;
        end
        check("abort no done", 80'(n_done), 80'(0));
        encrypt(64'h0, 80'h0, 0, 64'h5579C1387B228445, "after_rst");

        for (int i = 0; i < 4; i++) begin
            pt  = {$urandom(), $urandom()};
            key = {$urandom(), $urandom(), 16'($urandom())};
            encrypt(pt, key, 0, ref_encrypt(pt, key), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
